// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
// Shared definitions for the ALU sequencer/arbiter:
//   - sequencer state encoding (IDLE, ISSUE, WAIT, RESP)
//   - opcode width and default operand/result widths and watchdog limit
package alu_arb_pkg;

    localparam int OPCODE_W    = 4;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_OUT_W   = 32;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// alu_rr_pick
// Two-way round-robin picker, purely combinational. The pointer register
// lives in the parent.
//   req0, req1 : requests
//   last       : index of the most recently granted requester
//   gnt        : one-hot winner (bit 0 = requester 0), zero when no request
module alu_rr_pick (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: default first so every path assigns gnt and no latch is inferred.
        gnt = 2'b00;
        if (req0 && req1) begin
            // Tie: the requester that was not served last time wins.
            gnt = last ? 2'b01 : 2'b10;
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Sequencer and two-port round-robin arbiter for the shared ALU. Grants one
// requester at a time, launches the ALU with a one-cycle start pulse, waits
// for done (with a watchdog), and returns result/flags to the owner.
//   clk, reset_a               : clock, asynchronous active-low reset
//   req*/dataa*/datab*/opcode* : per-requester job inputs
//   gnt0/gnt1                  : one-cycle grant (combinational, IDLE only)
//   rsp_valid0/rsp_valid1      : one-cycle response strobe to the owner
//   rsp_out/carry/zero/err     : shared captured response, held until next
//   alu_dataa/datab/opcode     : registered operands to the ALU
//   alu_start                  : ALU launch pulse
//   alu_out/carry/zero/done    : ALU results
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset_a,
    input  logic                req0,
    input  logic                req1,
    input  logic [DATA_W-1:0]   dataa0,
    input  logic [DATA_W-1:0]   datab0,
    input  logic [DATA_W-1:0]   dataa1,
    input  logic [DATA_W-1:0]   datab1,
    input  logic [OPCODE_W-1:0] opcode0,
    input  logic [OPCODE_W-1:0] opcode1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                rsp_valid0,
    output logic                rsp_valid1,
    output logic [OUT_W-1:0]    rsp_out,
    output logic                rsp_carry,
    output logic                rsp_zero,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   alu_dataa,
    output logic [DATA_W-1:0]   alu_datab,
    output logic [OPCODE_W-1:0] alu_opcode,
    output logic                alu_start,
    input  logic [OUT_W-1:0]    alu_out,
    input  logic                alu_carry,
    input  logic                alu_zero,
    input  logic                alu_done
);

    localparam int            WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t          state;
    logic            last;
    logic            owner;
    logic [WD_W-1:0] wd;
    logic [1:0]      pick_gnt;

    alu_rr_pick u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last),
        .gnt  (pick_gnt)
    );

    // Grants only exist in IDLE; gating with reset_a keeps them low while
    // reset is held even though the state register already reads IDLE.
    assign gnt0       = (state == ST_IDLE) && reset_a && pick_gnt[0];
    assign gnt1       = (state == ST_IDLE) && reset_a && pick_gnt[1];
    assign alu_start  = (state == ST_ISSUE);
    assign rsp_valid0 = (state == ST_RESP) && !owner;
    assign rsp_valid1 = (state == ST_RESP) &&  owner;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state      <= ST_IDLE;
            last       <= 1'b1;   // requester 0 wins the first tie
            owner      <= 1'b0;
            wd         <= '0;
            alu_dataa  <= '0;
            alu_datab  <= '0;
            alu_opcode <= '0;
            rsp_out    <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_gnt != 2'b00) begin
                        owner      <= pick_gnt[1];
                        last       <= pick_gnt[1];
                        alu_dataa  <= pick_gnt[1] ? dataa1  : dataa0;
                        alu_datab  <= pick_gnt[1] ? datab1  : datab0;
                        alu_opcode <= pick_gnt[1] ? opcode1 : opcode0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd    <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done takes priority over a watchdog expiry in the same cycle
                    if (alu_done) begin
                        rsp_out   <= alu_out;
                        rsp_carry <= alu_carry;
                        rsp_zero  <= alu_zero;
                        rsp_err   <= 1'b0;
                        state     <= ST_RESP;
                    end else if (wd == WD_LAST) begin
                        rsp_out   <= '0;
                        rsp_carry <= 1'b0;
                        rsp_zero  <= 1'b0;
                        rsp_err   <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench for alu_arbiter with a watchdog limit of 8. A
// behavioural ALU answers each start pulse after a chosen latency
// (0 = never). Directed vectors, multi-cycle corner sequences and a
// randomized run against a cycle-level reference of the arbitration rules.
module tb_alu_arbiter;

    localparam int TO = 8;

    typedef struct {
        logic [31:0] out;
        logic        c;
        logic        z;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        int          lat;
        logic [31:0] out;
        logic        c;
        logic        z;
        logic        err;
        int          dly;
    } vec_t;

    logic        clk;
    logic        reset_a;
    logic        req0, req1;
    logic [15:0] dataa0, datab0, dataa1, datab1;
    logic [3:0]  opcode0, opcode1;
    logic        gnt0, gnt1, rsp_valid0, rsp_valid1;
    logic [31:0] rsp_out;
    logic        rsp_carry, rsp_zero, rsp_err;
    logic [15:0] alu_dataa, alu_datab;
    logic [3:0]  alu_opcode;
    logic        alu_start;
    logic [31:0] alu_out;
    logic        alu_carry, alu_zero, alu_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // ALU model controls
    int fixed_lat  = 2;
    bit rand_lat   = 0;
    bit force_done = 0;
    int cur_lat    = 0;

    logic [75:0] all_out;
    assign all_out = {gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_out, rsp_carry,
                      rsp_zero, rsp_err, alu_dataa, alu_datab, alu_opcode, alu_start};

    alu_arbiter #(.DATA_W(16), .OUT_W(32), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_a    (reset_a),
        .req0       (req0),
        .req1       (req1),
        .dataa0     (dataa0),
        .datab0     (datab0),
        .dataa1     (dataa1),
        .datab1     (datab1),
        .opcode0    (opcode0),
        .opcode1    (opcode1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rsp_valid0 (rsp_valid0),
        .rsp_valid1 (rsp_valid1),
        .rsp_out    (rsp_out),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .alu_dataa  (alu_dataa),
        .alu_datab  (alu_datab),
        .alu_opcode (alu_opcode),
        .alu_start  (alu_start),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .alu_done   (alu_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Reference ALU: 0 add, 1 sub (carry = borrow), 2 and, 3 or, else xor.
    function automatic res_t ref_alu(input logic [15:0] a, input logic [15:0] b,
                                     input logic [3:0] op);
        res_t        r;
        logic [16:0] s;
        logic [15:0] d;
        r.c = 1'b0;
        case (op)
            4'd0: begin
                s     = {1'b0, a} + {1'b0, b};
                r.out = {15'd0, s};
                r.c   = s[16];
            end
            4'd1: begin
                d     = a - b;
                r.out = {16'd0, d};
                r.c   = (a < b);
            end
            4'd2:    r.out = {16'd0, a & b};
            4'd3:    r.out = {16'd0, a | b};
            default: r.out = {16'd0, a ^ b};
        endcase
        r.z = (r.out == 32'd0);
        return r;
    endfunction

    // Behavioural ALU: done pulses cur_lat cycles after the start cycle.
    initial begin
        int          done_at;
        logic [15:0] a_q, b_q;
        logic [3:0]  op_q;
        res_t        r;
        done_at = -1;
        a_q = '0; b_q = '0; op_q = '0;
        alu_done = 1'b0; alu_out = '0; alu_carry = 1'b0; alu_zero = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_a) begin
                done_at = -1;
            end else if (alu_start) begin
                cur_lat = rand_lat ? int'($urandom_range(0, 11)) : fixed_lat;
                a_q     = alu_dataa;
                b_q     = alu_datab;
                op_q    = alu_opcode;
                done_at = (cur_lat == 0) ? -1 : cyc + cur_lat;
            end
            @(posedge clk);
            #1;
            if (force_done) begin
                alu_done = 1'b1; alu_out = 32'hDEAD_BEEF; alu_carry = 1'b1; alu_zero = 1'b1;
            end else if (cyc == done_at) begin
                r = ref_alu(a_q, b_q, op_q);
                alu_done = 1'b1; alu_out = r.out; alu_carry = r.c; alu_zero = r.z;
            end else begin
                // garbage while not done, so unqualified captures show up
                alu_done = 1'b0; alu_out = $urandom; alu_carry = 1'b1; alu_zero = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Waits (bounded) for a strobe; at = cycle it was seen, -1 on expiry.
    task automatic wait_flag(input int which, output int at);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((which == 0 && gnt0) || (which == 1 && gnt1) ||
                (which == 2 && rsp_valid0) || (which == 3 && rsp_valid1) ||
                (which == 4 && alu_start)) begin
                at = cyc;
                return;
            end
        end
    endtask

    task automatic run_random(input int ncyc);
        bit          m_busy = 0;
        int          m_last = 1;
        int          m_owner = 0, m_g = 0, m_rc = -1, w;
        bit          m_err = 0;
        bit          drop0 = 0, drop1 = 0;
        logic [15:0] a_s = '0, b_s = '0;
        logic [3:0]  o_s = '0;
        logic [1:0]  exp_g, exp_v;
        res_t        r;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            if (drop0 || (!req0 && $urandom_range(0, 2) == 0)) begin
                req0    = drop0 ? 1'($urandom_range(0, 1)) : 1'b1;
                dataa0  = 16'($urandom);
                datab0  = 16'($urandom);
                opcode0 = 4'($urandom_range(0, 5));
                drop0   = 0;
            end
            if (drop1 || (!req1 && $urandom_range(0, 2) == 0)) begin
                req1    = drop1 ? 1'($urandom_range(0, 1)) : 1'b1;
                dataa1  = 16'($urandom);
                datab1  = 16'($urandom);
                opcode1 = 4'($urandom_range(0, 5));
                drop1   = 0;
            end
            @(negedge clk);
            exp_g = 2'b00;
            w     = 0;
            if (!m_busy && (req0 || req1)) begin
                w     = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
                exp_g = (w == 1) ? 2'b10 : 2'b01;
            end
            check("rnd_gnt", {gnt1, gnt0}, exp_g);
            drop0 = gnt0;
            drop1 = gnt1;
            if (exp_g != 2'b00) begin
                m_busy  = 1;
                m_last  = w;
                m_owner = w;
                m_g     = cyc;
                m_rc    = -1;
                a_s     = (w == 1) ? dataa1  : dataa0;
                b_s     = (w == 1) ? datab1  : datab0;
                o_s     = (w == 1) ? opcode1 : opcode0;
            end
            check("rnd_start", alu_start, m_busy && (cyc == m_g + 1));
            if (m_busy && cyc == m_g + 2) begin
                m_err = (cur_lat == 0) || (cur_lat > TO);
                m_rc  = m_g + 2 + (m_err ? TO : cur_lat);
            end
            exp_v = (m_busy && cyc == m_rc) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
            check("rnd_valid", {rsp_valid1, rsp_valid0}, exp_v);
            if (exp_v != 2'b00) begin
                r = ref_alu(a_s, b_s, o_s);
                if (m_err) check("rnd_rsp", {rsp_err, rsp_zero, rsp_carry, rsp_out}, {1'b1, 1'b0, 1'b0, 32'd0});
                else       check("rnd_rsp", {rsp_err, rsp_zero, rsp_carry, rsp_out}, {1'b0, r.z, r.c, r.out});
                m_busy = 0;
            end
        end
    endtask

    vec_t vecs[8];

    initial begin
        int g, s, v, r, nv;
        int gq_who[$];
        int gq_cyc[$];

        vecs[0] = '{16'd5,      16'd3,      4'd0, 2, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 4};
        vecs[1] = '{16'hFFFF,   16'd1,      4'd0, 3, 32'h0001_0000, 1'b1, 1'b0, 1'b0, 5};
        vecs[2] = '{16'd7,      16'd7,      4'd1, 1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 3};
        vecs[3] = '{16'd3,      16'd5,      4'd1, 4, 32'h0000_FFFE, 1'b1, 1'b0, 1'b0, 6};
        vecs[4] = '{16'hF0F0,   16'h0FF0,   4'd2, 8, 32'h0000_00F0, 1'b0, 1'b0, 1'b0, 10};
        vecs[5] = '{16'd1,      16'd2,      4'd0, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 10};
        vecs[6] = '{16'h1234,   16'h00FF,   4'd4, 9, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 10};
        vecs[7] = '{16'hAAAA,   16'h5555,   4'd3, 2, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 4};

        // Reset with both requesters already asking.
        reset_a = 1'b0;
        req0 = 1'b1; dataa0 = 16'd10;  datab0 = 16'd20; opcode0 = 4'd0;
        req1 = 1'b1; dataa1 = 16'd100; datab1 = 16'd23; opcode1 = 4'd1;
        fixed_lat = 1;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_out, '0);

        // Release: tie goes to requester 0, then strict alternation.
        @(posedge clk);
        #1;
        reset_a = 1'b1;
        r = cyc;
        for (int k = 0; k < 60 && gq_who.size() < 4; k++) begin
            @(negedge clk);
            if (gnt0) begin gq_who.push_back(0); gq_cyc.push_back(cyc); end
            if (gnt1) begin gq_who.push_back(1); gq_cyc.push_back(cyc); end
        end
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        check("alt_count", gq_who.size(), 4);
        if (gq_who.size() == 4) begin
            check("alt_first_cycle", gq_cyc[0], r);
            for (int k = 0; k < 4; k++) check("alt_order", gq_who[k], k % 2);
            for (int k = 1; k < 4; k++) check("alt_turnaround", gq_cyc[k] - gq_cyc[k-1], 4);
        end
        wait_flag(3, v);
        check("alt_last_rsp", {rsp_err, rsp_zero, rsp_carry, rsp_out}, {1'b0, 1'b0, 1'b0, 32'd77});

        // Table of single-requester jobs (latency, watchdog boundary, timeouts).
        foreach (vecs[i]) begin
            fixed_lat = vecs[i].lat;
            @(posedge clk);
            #1;
            req0 = 1'b1; dataa0 = vecs[i].a; datab0 = vecs[i].b; opcode0 = vecs[i].op;
            wait_flag(0, g);
            @(posedge clk);
            #1;
            // operands must already be latched; scramble the inputs
            req0 = 1'b0; dataa0 = 16'($urandom); datab0 = 16'($urandom); opcode0 = 4'($urandom);
            wait_flag(4, s);
            check("vec_start_cycle", s - g, 1);
            wait_flag(2, v);
            check("vec_rsp_delay", v - g, vecs[i].dly);
            check("vec_rsp", {rsp_err, rsp_zero, rsp_carry, rsp_out},
                  {vecs[i].err, vecs[i].z, vecs[i].c, vecs[i].out});
            check("vec_alu_ops", {alu_dataa, alu_datab, alu_opcode},
                  {vecs[i].a, vecs[i].b, vecs[i].op});
            check("vec_no_rsp1", rsp_valid1, 1'b0);
        end

        // Spurious done while idle: ignored, response registers hold.
        nv = 0;
        @(negedge clk);
        force_done = 1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid0 || rsp_valid1 || alu_start || gnt0 || gnt1) nv++;
        end
        force_done = 0;
        @(negedge clk);
        check("spur_quiet", nv, 0);
        check("spur_hold", {rsp_err, rsp_zero, rsp_carry, rsp_out}, {1'b0, 1'b0, 1'b0, 32'h0000_FFFF});

        // Reset in the middle of WAIT, then requester 1 alone.
        fixed_lat = 0;
        @(posedge clk);
        #1;
        req0 = 1'b1; dataa0 = 16'd9; datab0 = 16'd9; opcode0 = 4'd0;
        wait_flag(0, g);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_a = 1'b0;
        #1;
        check("rst_mid_outputs", all_out, '0);
        req1 = 1'b1; dataa1 = 16'd40; datab1 = 16'd2; opcode1 = 4'd1;
        fixed_lat = 2;
        nv = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid0 || rsp_valid1 || gnt0 || gnt1 || alu_start) nv++;
        end
        check("rst_mid_quiet", nv, 0);
        @(posedge clk);
        #1;
        reset_a = 1'b1;
        r = cyc;
        wait_flag(1, g);
        check("rst_gnt1_cycle", g, r);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        wait_flag(3, v);
        check("rst_rsp_delay", v - g, 4);
        check("rst_rsp", {rsp_err, rsp_zero, rsp_carry, rsp_out}, {1'b0, 1'b0, 1'b0, 32'd38});

        // Randomized traffic with random ALU latencies.
        rand_lat = 1;
        run_random(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and two-port arbiter for the shared 16-bit ALU. Two independent requesters submit operand/opcode jobs; the block grants one at a time by round-robin, launches the ALU with a single-cycle start pulse, waits for its done flag, and returns the 32-bit result and flags to the granted requester. A watchdog aborts jobs whose done flag never arrives.

## Interface
- DATA_W, 16: operand width
- OUT_W, 32: result width
- TIMEOUT, 64: maximum WAIT cycles before abort (≥2)
- clk  in  1  system clock, rising edge
- reset_a  in  1  asynchronous reset, active-low
- req0 / req1  in  1  job request, held until matching gnt
- dataa0, datab0 / dataa1, datab1  in  DATA_W  operands per requester
- opcode0 / opcode1  in  4  ALU opcode per requester
- gnt0 / gnt1  out  1  one-cycle grant; operands latched this cycle
- rsp_valid0 / rsp_valid1  out  1  one-cycle result strobe
- rsp_out  out  OUT_W  result (shared, qualified by rsp_valid*)
- rsp_carry, rsp_zero  out  1  captured ALU flags
- rsp_err  out  1  job timed out
- alu_dataa, alu_datab  out  DATA_W  to ALU
- alu_opcode  out  4  to ALU
- alu_start  out  1  ALU launch pulse
- alu_out  in  OUT_W; alu_carry, alu_zero, alu_done  in  1  from ALU

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req, pick winner; assert gnt of winner (combinational, same cycle), latch its operands/opcode into alu_* registers, record owner, go ISSUE. No req: stay.
- Round-robin: single pointer last; only one requesting → that one wins; both → the one ≠ last. last updates on grant.
- ISSUE: alu_start=1 for exactly this cycle; clear watchdog; go WAIT.
- WAIT: on alu_done=1, capture alu_out/carry/zero, rsp_err=0, go RESP. Else increment watchdog; at count TIMEOUT-1 without done: rsp_out=0, carry=zero=0, rsp_err=1, go RESP. done and timeout same cycle → done wins.
- RESP: rsp_valid<owner>=1 for one cycle; go IDLE. rsp_* hold until next capture.
- alu_dataa/datab/opcode stable from ISSUE through RESP.
- req dropped after gnt is ignored; req still high after RESP starts a new job.
- alu_done outside WAIT ignored.

## Timing
- Reset (reset_a low, any time, incl. mid-job): state=IDLE, last=1 (req0 wins first tie), all outputs 0, watchdog 0. In-flight job discarded, no rsp_valid.
- Grant cycle G (IDLE); alu_start at G+1; done sampled high at cycle D ≥ G+2 → rsp_valid at D+1; next grant no earlier than D+2.
- Minimum turnaround: 4 cycles grant-to-grant.
- Timeout: rsp_valid with rsp_err at G+2+TIMEOUT.

## Structure
- Package alu_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), opcode width 4, default DATA_W/OUT_W.
- Sub-module alu_rr_pick: 2-way round-robin picker (req0, req1, last → gnt vector); purely combinational, pointer register stays in parent.

## Test plan
- req0 only, dataa0=5, datab0=3, opcode add, model ALU done 2 cycles after start → gnt0 at G, alu_start G+1, rsp_valid0 G+4, rsp_out=8, rsp_err=0.
- req0 and req1 both high from reset → gnt0 first, then gnt1; both held continuously → strict alternation 0,1,0,1.
- ALU never raises done, TIMEOUT=8 → rsp_valid at G+10, rsp_err=1, rsp_out=0; next job proceeds normally.
- done asserted on the timeout cycle → rsp_err=0, result captured.
- reset_a low during WAIT → all outputs 0 next edge-independent, no rsp_valid; after release req1 alone → gnt1.
- Spurious alu_done in IDLE → no state change, no rsp_valid.
